// File: rtl/mc_ctrl_fsm_if.sv
// rtl/mc_ctrl_fsm_if.sv - memory request/ready handshake between control FSM and unified memory port
//
// Signals:
//   mem_req   - memory request, held until mem_ready
//   mem_we    - store qualifier for mem_req
//   adr_src   - memory address select: 0 = PC, 1 = ALU-out register
//   mem_ready - memory completes the current request this cycle
// Modports: master (control FSM side), slave (memory side).

interface mc_ctrl_fsm_if;
    logic mem_req;
    logic mem_we;
    logic adr_src;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output adr_src,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  adr_src,
        output mem_ready
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// rtl/mc_ctrl_fsm.sv - multi-cycle RISC-V main control FSM
//
// Sequences fetch/decode/execute/memory/writeback over a shared ALU, register
// file and unified memory port. Outputs are Moore (state only) except the
// FETCH strobes gated by mem_ready and the BRANCH pc_write gated by zero/func3.
//
// Ports:
//   clk, rst      - core clock; asynchronous active-high reset
//   mem           - memory handshake (mem_req, mem_we, adr_src, mem_ready)
//   opcode, func3 - instruction register fields
//   zero          - ALU zero flag
//   ir_write, pc_write, reg_write - datapath write strobes
//   alu_src_a, alu_src_b, ALUOp, alu_imm, result_src - datapath selects
//   illegal       - sticky illegal-instruction flag (TRAP state)
//   instret       - retired instruction count
//   state_o       - current state encoding
//
// Optional feature: MC_CTRL_PERF_EN enables the 32-bit instret counter;
// when undefined instret is tied to zero.

module mc_ctrl_fsm (
    input  logic              clk,
    input  logic              rst,
    mc_ctrl_fsm_if.master     mem,
    input  logic [6:0]        opcode,
    input  logic [2:0]        func3,
    input  logic              zero,
    output logic              ir_write,
    output logic              pc_write,
    output logic              reg_write,
    output logic [1:0]        alu_src_a,
    output logic [1:0]        alu_src_b,
    output logic [1:0]        ALUOp,
    output logic              alu_imm,
    output logic [1:0]        result_src,
    output logic              illegal,
    output logic [31:0]       instret,
    output logic [3:0]        state_o
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9,
        JAL    = 4'd10,
        TRAP   = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem.mem_req = 1'b0;
        mem.mem_we  = 1'b0;
        mem.adr_src = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        ALUOp       = 2'b00;
        alu_imm     = 1'b0;
        result_src  = 2'b00;
        illegal     = 1'b0;

        case (state_q)
            FETCH: begin
                // ALU computes PC+4 while the instruction is read
                mem.mem_req = 1'b1;
                alu_src_b   = 2'b10;
                result_src  = 2'b10;
                if (mem.mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = DECODE;
                end
            end
            DECODE: begin
                // old PC + imm: branch/jump target parked in ALU-out
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LOAD, OP_STORE: state_d = MEMADR;
                    OP_RTYPE:          state_d = EXECR;
                    OP_ITYPE:          state_d = EXECI;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    default:           state_d = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LOAD) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                mem.mem_req = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWR: begin
                mem.mem_req = 1'b1;
                mem.mem_we  = 1'b1;
                mem.adr_src = 1'b1;
                if (mem.mem_ready) state_d = FETCH;
            end
            EXECR: begin
                alu_src_a = 2'b10;
                ALUOp     = 2'b10;
                state_d   = ALUWB;
            end
            EXECI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                ALUOp     = 2'b10;
                alu_imm   = 1'b1;
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BRANCH: begin
                alu_src_a = 2'b10;
                ALUOp     = 2'b01;
                pc_write  = ((func3 == 3'b000) && zero) || ((func3 == 3'b001) && !zero);
                state_d   = ((func3 == 3'b000) || (func3 == 3'b001)) ? FETCH : TRAP;
            end
            JAL: begin
                // PC <- target; ALU then forms old PC + 4 for the link write in ALUWB
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            TRAP: begin
                illegal = 1'b1;
            end
            default: begin
                state_d = FETCH;
            end
        endcase

        // Reset is asynchronous on the outputs too: a pending request drops at once
        if (rst) begin
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            mem.adr_src = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 2'b00;
            alu_src_b   = 2'b00;
            ALUOp       = 2'b00;
            alu_imm     = 1'b0;
            result_src  = 2'b00;
            illegal     = 1'b0;
        end
    end

    assign state_o = state_q;

`ifdef MC_CTRL_PERF_EN
    logic        retire;
    logic [31:0] instret_q, instret_d;

    // An instruction retires on the edge that leaves its final state
    assign retire = (state_q == ALUWB) || (state_q == MEMWB) ||
                    ((state_q == BRANCH) && ((func3 == 3'b000) || (func3 == 3'b001))) ||
                    ((state_q == MEMWR) && mem.mem_ready);

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            instret_q <= 32'd0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = 32'h0;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// tb/tb_mc_ctrl_fsm.sv - directed self-checking bench for mc_ctrl_fsm

module tb_mc_ctrl_fsm;

`ifdef MC_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic        clk;
    logic        rst;
    logic [6:0]  opcode;
    logic [2:0]  func3;
    logic        zero;
    logic        ir_write;
    logic        pc_write;
    logic        reg_write;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  ALUOp;
    logic        alu_imm;
    logic [1:0]  result_src;
    logic        illegal;
    logic [31:0] instret;
    logic [3:0]  state_o;

    int n_checks;
    int n_fail;
    logic [31:0] exp_ret;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .mem        (bus),
        .opcode     (opcode),
        .func3      (func3),
        .zero       (zero),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUOp      (ALUOp),
        .alu_imm    (alu_imm),
        .result_src (result_src),
        .illegal    (illegal),
        .instret    (instret),
        .state_o    (state_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_ret(input string tag);
        chk(tag, instret, PERF ? exp_ret : 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        exp_ret  = 32'd0;
        rst = 1'b1;
        opcode = 7'd0;
        func3 = 3'd0;
        zero = 1'b0;
        bus.mem_ready = 1'b0;

        // Reset state
        nxt(); nxt();
        chk("rst_state", state_o, 0);
        chk("rst_mem_req", bus.mem_req, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_ir_write", ir_write, 0);
        chk("rst_pc_write", pc_write, 0);
        chk("rst_reg_write", reg_write, 0);
        chk("rst_alu_src_b", alu_src_b, 0);
        chk("rst_result_src", result_src, 0);
        chk("rst_aluop", ALUOp, 0);
        chk("rst_illegal", illegal, 0);
        chk("rst_instret", instret, 0);

        rst = 1'b0;
        #1;
        chk("fetch_mem_req", bus.mem_req, 1);
        chk("fetch_state", state_o, 0);
        chk("fetch_alu_src_b", alu_src_b, 2);
        chk("fetch_result_src", result_src, 2);
        chk("fetch_ir_write_wait", ir_write, 0);
        nxt();
        chk("fetch_wait_state", state_o, 0);
        chk("fetch_wait_mem_req", bus.mem_req, 1);

        // Reset mid-FETCH drops mem_req without a clock edge
        #2 rst = 1'b1;
        #1;
        chk("rst_async_mem_req", bus.mem_req, 0);
        chk("rst_async_alu_src_b", alu_src_b, 0);
        nxt();
        rst = 1'b0;
        #1;
        chk("rel_state", state_o, 0);
        chk("rel_mem_req", bus.mem_req, 1);

        // R-type, zero-wait memory
        opcode = OP_RTYPE;
        bus.mem_ready = 1'b1;
        #1;
        chk("r_ir_write", ir_write, 1);
        chk("r_pc_write", pc_write, 1);
        nxt();
        chk("r_decode", state_o, 1);
        chk("r_dec_a", alu_src_a, 1);
        chk("r_dec_b", alu_src_b, 1);
        chk("r_dec_mem_req", bus.mem_req, 0);
        nxt();
        chk("r_execr", state_o, 6);
        chk("r_execr_aluop", ALUOp, 2);
        chk("r_execr_a", alu_src_a, 2);
        chk("r_execr_b", alu_src_b, 0);
        chk("r_execr_reg_write", reg_write, 0);
        chk("r_execr_alu_imm", alu_imm, 0);
        nxt();
        chk("r_aluwb", state_o, 8);
        chk("r_aluwb_reg_write", reg_write, 1);
        chk("r_aluwb_result_src", result_src, 0);
        nxt();
        chk("r_back_fetch", state_o, 0);
        chk("r_fetch_reg_write", reg_write, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("r_instret");

        // Load with three wait cycles in MEMRD
        opcode = OP_LOAD;
        nxt();
        chk("ld_decode", state_o, 1);
        bus.mem_ready = 1'b0;
        nxt();
        chk("ld_memadr", state_o, 2);
        chk("ld_memadr_a", alu_src_a, 2);
        chk("ld_memadr_b", alu_src_b, 1);
        chk("ld_memadr_mem_req", bus.mem_req, 0);
        for (int i = 0; i < 4; i++) begin
            nxt();
            chk("ld_memrd", state_o, 3);
            chk("ld_memrd_mem_req", bus.mem_req, 1);
            chk("ld_memrd_adr_src", bus.adr_src, 1);
            chk("ld_memrd_mem_we", bus.mem_we, 0);
        end
        bus.mem_ready = 1'b1;
        nxt();
        chk("ld_memwb", state_o, 4);
        chk("ld_memwb_reg_write", reg_write, 1);
        chk("ld_memwb_result_src", result_src, 1);
        chk("ld_memwb_mem_req", bus.mem_req, 0);
        nxt();
        chk("ld_back_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("ld_instret");

        // Store
        opcode = OP_STORE;
        nxt();
        chk("st_decode", state_o, 1);
        nxt();
        chk("st_memadr", state_o, 2);
        nxt();
        chk("st_memwr", state_o, 5);
        chk("st_mem_req", bus.mem_req, 1);
        chk("st_mem_we", bus.mem_we, 1);
        chk("st_adr_src", bus.adr_src, 1);
        nxt();
        chk("st_back_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("st_instret");

        // BEQ taken
        opcode = OP_BRANCH;
        func3 = 3'b000;
        zero = 1'b1;
        nxt();
        chk("beq_t_decode", state_o, 1);
        nxt();
        chk("beq_t_branch", state_o, 9);
        chk("beq_t_aluop", ALUOp, 1);
        chk("beq_t_pc_write", pc_write, 1);
        chk("beq_t_a", alu_src_a, 2);
        chk("beq_t_b", alu_src_b, 0);
        nxt();
        chk("beq_t_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("beq_t_instret");

        // BEQ not taken
        zero = 1'b0;
        nxt();
        nxt();
        chk("beq_n_branch", state_o, 9);
        chk("beq_n_pc_write", pc_write, 0);
        nxt();
        chk("beq_n_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;

        // BNE taken, then zero flips within the cycle
        func3 = 3'b001;
        zero = 1'b0;
        nxt();
        nxt();
        chk("bne_branch", state_o, 9);
        chk("bne_pc_write", pc_write, 1);
        zero = 1'b1;
        #1;
        chk("bne_zero_pc_write", pc_write, 0);
        nxt();
        chk("bne_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("bne_instret");

        // JAL
        opcode = OP_JAL;
        zero = 1'b0;
        nxt();
        nxt();
        chk("jal_state", state_o, 10);
        chk("jal_pc_write", pc_write, 1);
        chk("jal_a", alu_src_a, 1);
        chk("jal_b", alu_src_b, 2);
        chk("jal_reg_write", reg_write, 0);
        nxt();
        chk("jal_aluwb", state_o, 8);
        chk("jal_aluwb_reg_write", reg_write, 1);
        nxt();
        chk("jal_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("jal_instret");

        // I-type
        opcode = OP_ITYPE;
        nxt();
        nxt();
        chk("execi_state", state_o, 7);
        chk("execi_alu_imm", alu_imm, 1);
        chk("execi_aluop", ALUOp, 2);
        chk("execi_b", alu_src_b, 1);
        nxt();
        chk("execi_aluwb", state_o, 8);
        nxt();
        chk("execi_fetch", state_o, 0);
        exp_ret = exp_ret + 32'd1;
        chk_ret("execi_instret");

        // Counter wrap
`ifdef MC_CTRL_PERF_EN
        force dut.instret_q = 32'hFFFF_FFFF;
        #1;
        release dut.instret_q;
        exp_ret = 32'hFFFF_FFFF;
`endif
        opcode = OP_RTYPE;
        nxt();
        nxt();
        nxt();
        chk("wrap_aluwb", state_o, 8);
        nxt();
        exp_ret = exp_ret + 32'd1;
        chk_ret("wrap_instret");

        // Branch with unsupported func3 traps
        opcode = OP_BRANCH;
        func3 = 3'b010;
        zero = 1'b1;
        nxt();
        nxt();
        chk("bad_br_state", state_o, 9);
        chk("bad_br_pc_write", pc_write, 0);
        nxt();
        chk("bad_br_trap", state_o, 11);
        chk("bad_br_illegal", illegal, 1);
        chk_ret("bad_br_instret");

        rst = 1'b1;
        nxt();
        rst = 1'b0;
        #1;
        exp_ret = 32'd0;
        chk("rst2_illegal", illegal, 0);
        chk("rst2_state", state_o, 0);
        chk("rst2_instret", instret, 0);

        // Illegal opcode
        opcode = 7'b0000000;
        func3 = 3'b000;
        bus.mem_ready = 1'b1;
        nxt();
        chk("ill_decode", state_o, 1);
        nxt();
        chk("ill_trap", state_o, 11);
        chk("ill_illegal", illegal, 1);
        for (int i = 0; i < 10; i++) begin
            bus.mem_ready = i[0];
            opcode = OP_RTYPE;
            nxt();
            chk("ill_no_mem_req", bus.mem_req, 0);
            chk("ill_stay", state_o, 11);
            chk("ill_sticky", illegal, 1);
        end
        chk("ill_pc_write", pc_write, 0);
        chk("ill_reg_write", reg_write, 0);
        rst = 1'b1;
        #1;
        chk("ill_rst_clear", illegal, 0);
        nxt();
        rst = 1'b0;
        #1;
        chk("ill_rst_state", state_o, 0);
        chk("ill_rst_mem_req", bus.mem_req, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mc_ctrl_fsm.md
# mc_ctrl_fsm

Multi-cycle main control FSM for the RISC-V core. It sequences fetch, decode, execute, memory and writeback over a shared ALU, register file and unified memory port. Each cycle it drives the 2-bit ALUOp class code consumed by the ALU control decoder, plus datapath mux selects and write strobes. It sits between the instruction register and the datapath and handshakes with memory through a req/ready pair.

## Interface
Parameters:
- none.

Ports (clock and reset first):
- clk  in  1  core clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- opcode  in  7  instruction register bits [6:0].
- func3  in  3  instruction register bits [14:12]; used for branch condition.
- zero  in  1  ALU zero flag, valid in the same cycle as the ALU result.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held until mem_ready.
- mem_we  out  1  store qualifier for mem_req.
- adr_src  out  1  memory address select: 0 = PC, 1 = ALU-out register.
- ir_write  out  1  load instruction register (and old-PC register).
- pc_write  out  1  load PC from the result mux.
- reg_write  out  1  register file write strobe.
- alu_src_a  out  2  ALU A select: 00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = immediate, 10 = constant 4.
- ALUOp  out  2  class to the ALU decoder: 00 = ADD, 01 = SUB, 10 = decode func3/func7.
- alu_imm  out  1  high in EXECI; the decoder ignores func7[5] for func3=000, so ADDI is never decoded as SUB.
- result_src  out  2  result mux: 00 = ALU-out register, 01 = memory data, 10 = live ALU result.
- illegal  out  1  sticky illegal-instruction flag; the core is halted while it is set.
- instret  out  32  count of retired instructions.
- state_o  out  4  current state encoding, for debug.

## Operation
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, TRAP=11.
- Moore outputs depend on state only, except that strobes gated by mem_ready, zero or func3 are said so below. Any output not listed for a state is 0.
- FETCH
  - Outputs: mem_req=1, adr_src=0, a=00, b=10, ALUOp=00, result_src=10.
  - On mem_ready: ir_write=1 and pc_write=1, then go to DECODE. Otherwise stay.
- DECODE
  - Outputs: a=01, b=01, ALUOp=00 (branch/jump target into ALU-out).
  - Dispatch on opcode:
    - 0000011 or 0100011 → MEMADR.
    - 0110011 → EXECR.
    - 0010011 → EXECI.
    - 1100011 → BRANCH.
    - 1101111 → JAL.
    - Anything else → TRAP.
- MEMADR
  - Outputs: a=10, b=01, ALUOp=00.
  - Next: MEMRD if opcode=0000011, else MEMWR.
- MEMRD
  - Outputs: mem_req=1, adr_src=1.
  - MEMWB on mem_ready, else stay.
- MEMWB: result_src=01, reg_write=1; then FETCH.
- MEMWR
  - Outputs: mem_req=1, mem_we=1, adr_src=1.
  - FETCH on mem_ready, else stay.
- EXECR: a=10, b=00, ALUOp=10; then ALUWB.
- EXECI: a=10, b=01, ALUOp=10, alu_imm=1; then ALUWB.
- ALUWB: result_src=00, reg_write=1; then FETCH.
- BRANCH
  - Outputs: a=10, b=00, ALUOp=01, result_src=00.
  - pc_write = (func3==000 & zero) | (func3==001 & ~zero).
  - If func3 is not 000/001, go to TRAP with pc_write=0. Otherwise go to FETCH.
- JAL
  - Outputs: a=01, b=10, ALUOp=00, result_src=00, pc_write=1 (PC ← target).
  - Next: ALUWB, which writes old PC+4 to rd.
- TRAP: illegal=1, all strobes 0. Stays until rst.
- mem_ready outside FETCH/MEMRD/MEMWR is ignored.

## Timing
- While rst is high:
  - state=FETCH, illegal=0, instret=0.
  - mem_req, mem_we, ir_write, pc_write, reg_write forced to 0.
  - Selects are 0 and ALUOp=00.
- First mem_req is driven in the cycle after rst deasserts.
- Latency with zero-wait memory (mem_ready=1 in the first request cycle):
  - R/I/JAL: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
- Each extra wait cycle on a memory state adds 1 cycle.
- mem_req and mem_we stay stable from assertion until the cycle mem_ready is sampled high; they are never withdrawn early.
- Reset asserted mid-request drops mem_req immediately (asynchronously). Memory must discard the pending access.

## Configuration
- MC_CTRL_PERF_EN defined:
  - instret is a 32-bit register that increments by 1 on the clock edge leaving ALUWB, MEMWB, BRANCH (non-trap) and MEMWR (mem_ready=1).
  - It wraps from 0xFFFFFFFF to 0 and resets to 0.
- MC_CTRL_PERF_EN undefined: instret is tied to 32'h0 and no counter flops exist.

## Test plan
- Reset mid-FETCH with mem_req=1: rst high → mem_req=0 in the same cycle. After release, state_o=0 and mem_req=1 in the next cycle.
- R-type (opcode 0110011), mem_ready always 1:
  - state_o sequence is 0,1,6,8,0.
  - ALUOp=10 in EXECR.
  - reg_write=1 only in ALUWB.
  - instret increments by 1 with PERF enabled.
- Load with mem_ready held low 3 cycles in MEMRD:
  - state_o sequence is 0,1,2,3,3,3,3,4,0.
  - mem_req and adr_src=1 are stable throughout MEMRD.
- BEQ (func3=000):
  - zero=1 → pc_write=1 in BRANCH with ALUOp=01.
  - Repeat with zero=0 → pc_write=0.
  - BNE with zero=0 → pc_write=1.
- Illegal opcode 0000000 in DECODE:
  - Next state is TRAP and illegal=1.
  - No mem_req is asserted for 10 cycles.
  - Only rst clears illegal.
- PERF wrap: preload 0xFFFFFFFF through a bench force, retire one instruction → instret=0. With the macro undefined, instret is always 0.
